// File: rtl/pipeline_control.sv
// Pipeline advance/hold/squash control for the F/D, D/X, X/M, M/W latches and PC.
// Define PIPELINE_CONTROL_PERF_EN to add the stall/flush/multdiv performance counters.
module pipeline_control #(
  parameter logic [4:0] LW_OPCODE  = 5'b01000,
  parameter int         MD_TIMEOUT = 40,
  parameter int         CNT_W      = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_rs_used,
  input  logic       d_rt_used,
  input  logic [4:0] x_opcode,
  input  logic [4:0] x_rd,
  input  logic       x_md_start,
  input  logic       md_ready,
  input  logic       x_branch_taken,
  output logic       pc_enable,
  output logic       fd_enable,
  output logic       dx_enable,
  output logic       xm_enable,
  output logic       mw_enable,
  output logic       fd_flush,
  output logic       dx_flush,
  output logic       xm_flush,
`ifdef PIPELINE_CONTROL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] md_cycles,
`endif
  output logic       md_error
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MD_TIMEOUT);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_set;
  logic             load_hazard;
  logic             md_release;

  assign load_hazard = (x_opcode == LW_OPCODE) && (x_rd != 5'd0) &&
                       ((d_rs_used && (d_rs == x_rd)) || (d_rt_used && (d_rt == x_rd)));

  // A timeout releases the pipeline exactly like a late md_ready.
  assign md_release = md_ready || (cnt_reg == TIMEOUT_CNT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      md_error  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (err_set)
        md_error <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_set    = 1'b0;
    case (state_reg)
      RUN: begin
        if (!x_branch_taken && x_md_start && !md_ready) begin
          state_next = MD_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      MD_WAIT: begin
        if (md_release) begin
          state_next = RUN;
          cnt_next   = '0;
          err_set    = !md_ready;
        end else if (cnt_reg < TIMEOUT_CNT) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pc_enable = 1'b1;
    fd_enable = 1'b1;
    dx_enable = 1'b1;
    xm_enable = 1'b1;
    mw_enable = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    xm_flush  = 1'b0;
    case (state_reg)
      RUN: begin
        if (x_branch_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (x_md_start && !md_ready) begin
          {pc_enable, fd_enable, dx_enable, xm_enable} = 4'b0000;
          xm_flush = 1'b1;
        end else if (load_hazard) begin
          {pc_enable, fd_enable} = 2'b00;
          dx_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        if (!md_release) begin
          {pc_enable, fd_enable, dx_enable, xm_enable} = 4'b0000;
          xm_flush = 1'b1;
        end
      end
      default: ;
    endcase
    // While clr is high the latches are cleared directly; keep every control quiet.
    if (clr) begin
      {pc_enable, fd_enable, dx_enable, xm_enable, mw_enable} = 5'b00000;
      {fd_flush, dx_flush, xm_flush} = 3'b000;
    end
  end

`ifdef PIPELINE_CONTROL_PERF_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
      md_cycles    <= '0;
    end else begin
      if (!pc_enable)
        stall_cycles <= stall_cycles + 32'd1;
      if (state_reg == RUN && x_branch_taken)
        flush_events <= flush_events + 32'd1;
      if (state_reg == MD_WAIT)
        md_cycles <= md_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized + directed bench for pipeline_control against a cycle-stamp reference model.
module tb_pipeline_control;

  localparam int MD_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] d_rs, d_rt, x_opcode, x_rd;
  logic       d_rs_used, d_rt_used, x_md_start, md_ready, x_branch_taken;
  logic       pc_enable, fd_enable, dx_enable, xm_enable, mw_enable;
  logic       fd_flush, dx_flush, xm_flush, md_error;
`ifdef PIPELINE_CONTROL_PERF_EN
  logic [31:0] stall_cycles, flush_events, md_cycles;
`endif

  pipeline_control dut (
    .clk(clk), .clr(clr),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .x_opcode(x_opcode), .x_rd(x_rd), .x_md_start(x_md_start), .md_ready(md_ready),
    .x_branch_taken(x_branch_taken),
    .pc_enable(pc_enable), .fd_enable(fd_enable), .dx_enable(dx_enable),
    .xm_enable(xm_enable), .mw_enable(mw_enable),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
`ifdef PIPELINE_CONTROL_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events), .md_cycles(md_cycles),
`endif
    .md_error(md_error)
  );

  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {pc_enable, fd_enable, dx_enable, xm_enable, mw_enable,
                 fd_flush, dx_flush, xm_flush, md_error};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: "waiting" plus the cycle stamp at which the multdiv started.
  bit          m_waiting = 1'b0;
  bit          m_err = 1'b0;
  int          m_start_cyc = 0;
  int          cyc = 0;
  logic [31:0] m_stall = '0, m_flush = '0, m_md = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit hazard();
    return (x_opcode == 5'b01000) && (x_rd != 5'd0) &&
           ((d_rs_used && d_rs == x_rd) || (d_rt_used && d_rt == x_rd));
  endfunction

  // {pc,fd,dx,xm,mw enables, fd,dx,xm flushes, md_error}
  function automatic logic [8:0] expect_outs();
    logic [7:0] ctl;
    if (clr) return 9'b0;
    if (m_waiting) begin
      if (md_ready || (cyc - m_start_cyc) >= MD_TIMEOUT) ctl = 8'b11111_000;
      else                                                ctl = 8'b00001_001;
    end else if (x_branch_taken)              ctl = 8'b11111_110;
    else if (x_md_start && !md_ready)         ctl = 8'b00001_001;
    else if (hazard())                        ctl = 8'b00111_010;
    else                                      ctl = 8'b11111_000;
    return {ctl, m_err};
  endfunction

  function automatic void model_edge(input logic [8:0] exp);
    if (clr) begin
      m_waiting = 1'b0; m_err = 1'b0;
      m_stall = '0; m_flush = '0; m_md = '0;
    end else begin
      if (!exp[8]) m_stall++;
      if (!m_waiting && x_branch_taken) m_flush++;
      if (m_waiting) m_md++;
      if (m_waiting) begin
        if (md_ready) m_waiting = 1'b0;
        else if ((cyc - m_start_cyc) >= MD_TIMEOUT) begin
          m_waiting = 1'b0; m_err = 1'b1;
        end
      end else if (!x_branch_taken && x_md_start && !md_ready) begin
        m_waiting = 1'b1; m_start_cyc = cyc;
      end
    end
    cyc++;
  endfunction

  // Called ~1 time unit after a rising edge with inputs set; checks, then crosses the next edge.
  task automatic apply(input string tag);
    logic [8:0] exp;
    #2;
    exp = expect_outs();
    check_eq(tag, 32'(outs), 32'(exp));
`ifdef PIPELINE_CONTROL_PERF_EN
    check_eq({tag, "_stall_cnt"}, stall_cycles, m_stall);
    check_eq({tag, "_flush_cnt"}, flush_events, m_flush);
    check_eq({tag, "_md_cnt"}, md_cycles, m_md);
`endif
    @(posedge clk);
    model_edge(exp);
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_rs_used = 1'b0; d_rt_used = 1'b0;
    x_opcode = 5'd0; x_rd = 5'd0; x_md_start = 1'b0; md_ready = 1'b0; x_branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    x_opcode = 5'b01000; x_rd = rd; d_rs = 5'd5; d_rs_used = 1'b1;
    d_rt = 5'd9; d_rt_used = 1'b1;
  endtask

  int lows;

  initial begin
    clr = 1'b1;
    idle_inputs();
    #2;
    check_eq("reset_outs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    apply("reset_hold");
    clr = 1'b0;
    apply("run_idle");

    // Load-use: one bubble, then the load has moved on.
    set_load_use(5'd5);
    apply("lu_stall");
    check_eq("lu_ctrl", 32'({pc_enable, fd_enable, dx_flush}), 32'b001);
    x_opcode = 5'd0;
    apply("lu_clear");
    check_eq("lu_after", 32'({pc_enable, dx_flush}), 32'b10);
    set_load_use(5'd0);
    apply("lu_rd0");
    check_eq("lu_rd0_ctrl", 32'(pc_enable), 32'd1);

    // Branch wins over a load hazard.
    set_load_use(5'd5);
    x_branch_taken = 1'b1;
    apply("br_hazard");
    check_eq("br_hazard_ctrl", 32'({pc_enable, fd_flush, dx_flush}), 32'b111);
    idle_inputs();

    // Multdiv answering on the 17th MD_WAIT cycle.
    lows = 0;
    x_md_start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      md_ready = (i == 17);
      apply("md17");
      if (!pc_enable) lows++;
    end
    check_eq("md17_stalls", 32'(lows), 32'd17);
    idle_inputs();
    apply("md17_done");
    check_eq("md17_err", 32'(md_error), 32'd0);

    // Two more load stalls and one more branch for the perf totals.
    set_load_use(5'd5); apply("lu2"); x_opcode = 5'd0; apply("lu2_clr");
    set_load_use(5'd5); apply("lu3"); idle_inputs();
    x_branch_taken = 1'b1; apply("br2"); idle_inputs();
    apply("perf_settle");
`ifdef PIPELINE_CONTROL_PERF_EN
    check_eq("perf_stall_total", stall_cycles, 32'd20);
    check_eq("perf_md_total", md_cycles, 32'd17);
    check_eq("perf_flush_total", flush_events, 32'd2);
`endif

    // Timeout: no md_ready ever.
    lows = 0;
    x_md_start = 1'b1;
    for (int i = 0; i < 41; i++) begin
      apply("md_timeout");
      if (!pc_enable) lows++;
    end
    check_eq("timeout_stalls", 32'(lows), 32'd40);
    idle_inputs();
    apply("timeout_after");
    check_eq("timeout_err", 32'(md_error), 32'd1);
    for (int i = 0; i < 5; i++) apply("err_sticky");
    check_eq("err_sticky_val", 32'(md_error), 32'd1);

    // Async reset in MD_WAIT cycle 5, between edges.
    x_md_start = 1'b1;
    for (int i = 0; i < 5; i++) apply("md_pre_rst");
    #2;
    clr = 1'b1;
    #1;
    check_eq("async_rst_now", 32'(outs), 32'd0);
    apply("async_rst_hold");
    clr = 1'b0;
    idle_inputs();
    apply("post_rst_run");
    check_eq("post_rst_err", 32'(md_error), 32'd0);

    // Randomized traffic: small register space so hazards occur often.
    for (int n = 0; n < 3000; n++) begin
      clr            = ($urandom_range(0, 299) == 0);
      d_rs           = 5'($urandom_range(0, 3));
      d_rt           = 5'($urandom_range(0, 3));
      d_rs_used      = 1'($urandom);
      d_rt_used      = 1'($urandom);
      x_opcode       = ($urandom_range(0, 1) == 0) ? 5'b01000 : 5'($urandom);
      x_rd           = 5'($urandom_range(0, 3));
      x_md_start     = ($urandom_range(0, 15) == 0);
      md_ready       = ($urandom_range(0, 49) == 0);
      x_branch_taken = ($urandom_range(0, 7) == 0);
      apply("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
